common_clock_fifo_reader: RTL

- Read-side master for a non-FWFT COMMON_CLOCK_FIFO: drives RE, absorbs the FIFO's 1-cycle read latency, presents words on a valid/ready output stream.
- Sits between the FIFO's read port and any downstream consumer that may stall.
- Sustains 1 word/cycle with a 2-entry skid buffer, never overreads, never loses data.

---
 rtl/common_clock_fifo_reader.sv | 108 ++++++++++
 1 files changed

// File: rtl/common_clock_fifo_reader.sv
// Read-side master for a non-FWFT common-clock FIFO: issues RE, absorbs the 1-cycle read latency
// and presents words on a valid/ready stream. Optional checker: FIFO_READER_PROTOCOL_CHECK_EN.
module common_clock_fifo_reader #(
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   FIFO_EMPTY,
    output logic                   FIFO_RE,
    input  logic                   FIFO_VALID,
    input  logic [DATA_WIDTH-1:0]  FIFO_DOUT,
    output logic                   M_VALID,
    input  logic                   M_READY,
    output logic [DATA_WIDTH-1:0]  M_DATA,
    output logic [COUNT_WIDTH-1:0] WORD_COUNT,
    output logic                   RD_ERR
);

    // M_DATA is the head slot itself; slot1 holds the second word.
    logic [DATA_WIDTH-1:0] slot1;
    logic [1:0]            buf_cnt;
    logic [1:0]            buf_cnt_next;
    logic                  inflight;
    logic                  armed;
    logic                  pop;
    logic                  capture;
    logic [2:0]            occupancy;

    assign pop = M_VALID && M_READY;

    // armed is low for the first edge after reset so a stray FIFO_VALID there is dropped.
`ifdef FIFO_READER_PROTOCOL_CHECK_EN
    assign capture = FIFO_VALID && inflight && armed;
`else
    assign capture = FIFO_VALID && armed;
`endif

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        occupancy    = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
        FIFO_RE      = RSTN && !FIFO_EMPTY && (occupancy < 3'd2);
        buf_cnt_next = buf_cnt;
        if (pop && !capture)
            buf_cnt_next = buf_cnt - 2'd1;
        else if (!pop && capture && buf_cnt != 2'd2)
            buf_cnt_next = buf_cnt + 2'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            buf_cnt    <= 2'd0;
            inflight   <= 1'b0;
            armed      <= 1'b0;
            M_VALID    <= 1'b0;
            M_DATA     <= '0;
            slot1      <= '0;
            WORD_COUNT <= '0;
        end else begin
            inflight <= FIFO_RE;
            armed    <= 1'b1;
            buf_cnt  <= buf_cnt_next;
            M_VALID  <= (buf_cnt_next != 2'd0);
            if (pop)
                WORD_COUNT <= WORD_COUNT + COUNT_WIDTH'(1);

            unique case ({pop, capture})
                2'b10: begin
                    if (buf_cnt == 2'd2)
                        M_DATA <= slot1;
                end
                2'b01: begin
                    if (buf_cnt == 2'd0)
                        M_DATA <= FIFO_DOUT;
                    else if (buf_cnt == 2'd1)
                        slot1 <= FIFO_DOUT;
                end
                2'b11: begin
                    // Head advances and the new word lands behind whatever remains.
                    if (buf_cnt == 2'd1) begin
                        M_DATA <= FIFO_DOUT;
                    end else begin
                        M_DATA <= slot1;
                        slot1  <= FIFO_DOUT;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_READER_PROTOCOL_CHECK_EN
    logic proto_violation;

    assign proto_violation = armed && (FIFO_VALID != inflight);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            RD_ERR <= 1'b0;
        else if (proto_violation)
            RD_ERR <= 1'b1;
    end
`else
    assign RD_ERR = 1'b0;
`endif

endmodule
